// File: rtl/tweak_pkg.sv
// tweak_pkg: shared encodings, state codes and IR field positions for the tweak CPU
package tweak_pkg;
    localparam logic [3:0] FMT_LDI = 4'h0;
    localparam logic [3:0] FMT_ALU = 4'h1;

    localparam logic [3:0] ALU_NOP = 4'h0;
    localparam logic [3:0] ALU_ADD = 4'h1;
    localparam logic [3:0] ALU_SUB = 4'h2;
    localparam logic [3:0] ALU_AND = 4'h3;
    localparam logic [3:0] ALU_OR  = 4'h4;
    localparam logic [3:0] ALU_XOR = 4'h5;
    localparam logic [3:0] ALU_ASL = 4'h6;
    localparam logic [3:0] ALU_ASR = 4'h7;

    typedef logic [2:0] state_t;
    localparam state_t S_IDLE   = 3'd0;
    localparam state_t S_FETCH  = 3'd1;
    localparam state_t S_WAIT   = 3'd2;
    localparam state_t S_DECODE = 3'd3;
    localparam state_t S_LOAD   = 3'd4;
    localparam state_t S_EXEC   = 3'd5;
    localparam state_t S_STORE  = 3'd6;
    localparam state_t S_HALT   = 3'd7;

    localparam int FMT_LSB = 28;
    localparam int OP_LSB  = 24;
    localparam int RA_LSB  = 20;
    localparam int RB_LSB  = 16;
    localparam int RD_LSB  = 12;
    localparam int IMM_W   = 24;
endpackage

// File: rtl/tweak_sequencer_if.sv
// tweak_sequencer_if: control, ROM and register-file strobes between sequencer and datapath
interface tweak_sequencer_if #(parameter int ADDR_W = 4, parameter int CNT_W = 16);
    logic              start;
    logic              step_mode;
    logic              halt_req;
    logic              pc_load;
    logic [ADDR_W-1:0] pc_load_val;
    logic              rom_rd;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_data;
    logic              rf_ld;
    logic [3:0]        rf_addra;
    logic [3:0]        rf_addrb;
    logic              rf_st;
    logic [3:0]        rf_st_addr;
    logic              wb_sel_imm;
    logic [31:0]       imm32;
    logic [3:0]        alu_op;
    logic              busy;
    logic              halted;
    logic              fault;
    logic [CNT_W-1:0]  retired;

    modport master (
        input  start, step_mode, halt_req, pc_load, pc_load_val, rom_data,
        output rom_rd, rom_addr, rf_ld, rf_addra, rf_addrb, rf_st, rf_st_addr,
               wb_sel_imm, imm32, alu_op, busy, halted, fault, retired
    );
    modport slave (
        output start, step_mode, halt_req, pc_load, pc_load_val, rom_data,
        input  rom_rd, rom_addr, rf_ld, rf_addra, rf_addrb, rf_st, rf_st_addr,
               wb_sel_imm, imm32, alu_op, busy, halted, fault, retired
    );
endinterface

// File: rtl/tweak_ir_fields.sv
// tweak_ir_fields: combinational split of an instruction word into datapath fields
module tweak_ir_fields import tweak_pkg::*; (
    input  logic [31:0] ir,
    output logic [3:0]  fmt,
    output logic [3:0]  alu_op,
    output logic [3:0]  rf_addra,
    output logic [3:0]  rf_addrb,
    output logic [3:0]  rf_st_addr,
    output logic [31:0] imm32
);
    always_comb begin
        fmt        = ir[FMT_LSB +: 4];
        alu_op     = fmt == FMT_ALU ? ir[OP_LSB +: 4] : ALU_NOP;
        rf_addra   = ir[RA_LSB +: 4];
        rf_addrb   = ir[RB_LSB +: 4];
        rf_st_addr = fmt == FMT_ALU ? ir[RD_LSB +: 4] : ir[OP_LSB +: 4];
        imm32      = {8'h00, ir[IMM_W-1:0]};
    end
endmodule

// File: rtl/tweak_sequencer.sv
// tweak_sequencer: single-clock fetch/decode/load/exec/store sequencer with one-cycle strobes
module tweak_sequencer import tweak_pkg::*; #(
    parameter int ADDR_W  = 4,
    parameter bit WRAP_EN = 1'b1,
    parameter int CNT_W   = 16
) (
    input logic CLK,
    input logic RESET,
    tweak_sequencer_if.master bus
);
    state_t            state, nxt;
    logic [ADDR_W-1:0] pc;
    logic [31:0]       ir;
    logic [CNT_W-1:0]  retired;
    logic              fault;
    logic [3:0]        fmt, dfmt;
    logic              last, parked;

    tweak_ir_fields f (
        .ir(ir), .fmt(fmt), .alu_op(bus.alu_op), .rf_addra(bus.rf_addra),
        .rf_addrb(bus.rf_addrb), .rf_st_addr(bus.rf_st_addr), .imm32(bus.imm32)
    );

    // IR is not loaded until the end of DECODE, so branch on the ROM word itself
    assign dfmt   = bus.rom_data[FMT_LSB +: 4];
    assign last   = pc == '1 && !WRAP_EN;
    assign parked = state == S_IDLE || state == S_HALT;

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE, S_HALT: nxt = bus.start ? S_FETCH : state;
            S_FETCH:        nxt = S_WAIT;
            S_WAIT:         nxt = S_DECODE;
            S_DECODE:       nxt = dfmt == FMT_ALU ? S_LOAD : dfmt == FMT_LDI ? S_STORE : S_HALT;
            S_LOAD:         nxt = S_EXEC;
            S_EXEC:         nxt = S_STORE;
            S_STORE:        nxt = last || bus.halt_req ? S_HALT : bus.step_mode ? S_IDLE : S_FETCH;
            default:        nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state   <= S_IDLE;
            pc      <= '0;
            ir      <= '0;
            retired <= '0;
            fault   <= 1'b0;
        end else begin
            state <= nxt;
            if (parked && bus.pc_load) pc <= bus.pc_load_val;
            if (state == S_DECODE) begin
                ir <= bus.rom_data;
                if (dfmt != FMT_LDI && dfmt != FMT_ALU) fault <= 1'b1;
            end
            if (state == S_STORE) begin
                if (!last) pc <= pc + 1'b1;
                if (~&retired) retired <= retired + 1'b1;
            end
        end
    end

    assign bus.rom_rd     = state == S_FETCH;
    assign bus.rom_addr   = pc;
    assign bus.rf_ld      = state == S_LOAD;
    assign bus.rf_st      = state == S_STORE;
    assign bus.wb_sel_imm = fmt == FMT_LDI;
    assign bus.busy       = !parked;
    assign bus.halted     = state == S_HALT;
    assign bus.fault      = fault;
    assign bus.retired    = retired;
endmodule

// File: tb/tb_tweak_sequencer.sv
// tb_tweak_sequencer: random and directed runs scored against a per-instruction reference model
module tb_tweak_sequencer;
    typedef struct packed {
        logic [3:0]  addr;
        logic        alu;
        logic [3:0]  dest;
        logic [3:0]  op;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [31:0] imm;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] rom [16];
    exp_t        q [$];
    int          checks = 0, failures = 0;
    int          cyc = 0, fetch_cyc = 0, st2 = 0;
    logic [3:0]  m_pc = '0;
    int          m_retired = 0;
    logic        m_fault = 1'b0;

    tweak_sequencer_if #(.ADDR_W(4), .CNT_W(16)) b ();
    tweak_sequencer_if #(.ADDR_W(4), .CNT_W(4))  b2 ();

    tweak_sequencer #(.ADDR_W(4), .WRAP_EN(1'b1), .CNT_W(16)) u (.CLK(CLK), .RESET(RESET), .bus(b.master));
    tweak_sequencer #(.ADDR_W(4), .WRAP_EN(1'b0), .CNT_W(4))  u2 (.CLK(CLK), .RESET(RESET), .bus(b2.master));

    always #5 CLK = ~CLK;

    // Synchronous ROM: the word appears the cycle after the read strobe and then holds
    always @(posedge CLK) if (b.rom_rd) b.rom_data <= rom[b.rom_addr];
    always @(posedge CLK) if (b2.rom_rd) b2.rom_data <= rom[b2.rom_addr];

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", n, act, exp);
        end
    endtask

    function automatic exp_t mk(logic [3:0] a, logic [31:0] w);
        exp_t e;
        e.addr = a;
        e.alu  = w[31:28] == 4'h1;
        e.dest = e.alu ? w[15:12] : w[27:24];
        e.op   = e.alu ? w[27:24] : 4'h0;
        e.ra   = w[23:20];
        e.rb   = w[19:16];
        e.imm  = {8'h00, w[23:0]};
        return e;
    endfunction

    function automatic logic [31:0] rand_word();
        logic [3:0] fm;
        fm = $urandom_range(0, 9) == 0 ? 4'($urandom_range(2, 15)) : 4'($urandom_range(0, 1));
        return {fm, 28'($urandom)};
    endfunction

    always @(negedge CLK) begin
        exp_t e;
        cyc++;
        if (b.rom_rd) fetch_cyc = cyc;
        if (b2.rf_st) st2++;
        if (b.rf_ld) begin
            chk("ld_latency", 32'(cyc - fetch_cyc), 32'd3);
            if (q.size() == 0) chk("ld_unexpected", 32'd1, 32'd0);
            else begin
                chk("rf_addra", 32'(b.rf_addra), 32'(q[0].ra));
                chk("rf_addrb", 32'(b.rf_addrb), 32'(q[0].rb));
            end
        end
        if (b.rf_st) begin
            if (q.size() == 0) chk("st_unexpected", 32'd1, 32'd0);
            else begin
                e = q.pop_front();
                chk("st_latency", 32'(cyc - fetch_cyc), e.alu ? 32'd5 : 32'd3);
                chk("st_pc", 32'(b.rom_addr), 32'(e.addr));
                chk("st_dest", 32'(b.rf_st_addr), 32'(e.dest));
                chk("wb_sel_imm", 32'(b.wb_sel_imm), 32'(!e.alu));
                chk("alu_op", 32'(b.alu_op), 32'(e.op));
                chk("imm32", b.imm32, e.imm);
            end
        end
    end

    task automatic go(bit ld, logic [3:0] v);
        b.pc_load = ld;
        b.pc_load_val = v;
        b.start = 1'b1;
        @(negedge CLK);
        b.pc_load = 1'b0;
        b.start = 1'b0;
    endtask

    // One start in step mode: either retires one instruction or faults into HALT
    task automatic run_one(bit ld, logic [3:0] v);
        logic [31:0] w;
        bit legal;
        if (ld) m_pc = v;
        w = rom[m_pc];
        legal = w[31:28] <= 4'h1;
        if (legal) q.push_back(mk(m_pc, w));
        go(ld, v);
        for (int i = 0; i < 50 && b.busy; i++) @(negedge CLK);
        chk("busy_drop", 32'(b.busy), 32'd0);
        if (legal) begin
            m_pc++;
            m_retired++;
        end else m_fault = 1'b1;
        chk("halted", 32'(b.halted), 32'(!legal));
        chk("fault", 32'(b.fault), 32'(m_fault));
        chk("retired", 32'(b.retired), 32'(m_retired));
        chk("pc", 32'(b.rom_addr), 32'(m_pc));
    endtask

    initial begin
        bit ld;
        logic [3:0] v;
        b.start = 0; b.step_mode = 1; b.halt_req = 0; b.pc_load = 0; b.pc_load_val = 0; b.rom_data = 0;
        b2.start = 0; b2.step_mode = 0; b2.halt_req = 0; b2.pc_load = 0; b2.pc_load_val = 0; b2.rom_data = 0;
        for (int i = 0; i < 16; i++) rom[i] = 32'h0;
        repeat (2) @(negedge CLK);
        chk("rst_rom_rd", 32'(b.rom_rd), 32'd0);
        chk("rst_rf_ld", 32'(b.rf_ld), 32'd0);
        chk("rst_rf_st", 32'(b.rf_st), 32'd0);
        chk("rst_busy", 32'(b.busy), 32'd0);
        chk("rst_halted", 32'(b.halted), 32'd0);
        chk("rst_fault", 32'(b.fault), 32'd0);
        chk("rst_retired", 32'(b.retired), 32'd0);
        chk("rst_pc", 32'(b.rom_addr), 32'd0);
        RESET = 1'b0;
        @(negedge CLK);

        rom[0] = 32'h00888888;
        run_one(0, 4'd0);
        rom[2] = 32'h11012000;
        run_one(1, 4'd2);
        rom[3] = 32'h2ABCDEF0;
        run_one(0, 4'd0);
        run_one(0, 4'd0);
        rom[4] = 32'h03123456;
        run_one(1, 4'd4);

        for (int k = 0; k < 40; k++) begin
            ld = $urandom_range(0, 3) == 0;
            v = 4'($urandom);
            rom[ld ? v : m_pc] = rand_word();
            run_one(ld, v);
        end

        // Free run across the wrap point, stopped by halt_req during the 17th instruction
        b.step_mode = 1'b0;
        for (int i = 0; i < 16; i++) rom[i] = {4'h0, 28'($urandom)};
        for (int i = 0; i < 17; i++) q.push_back(mk(4'(i), rom[i % 16]));
        go(1, 4'd0);
        for (int i = 0; i < 500 && q.size() > 1; i++) @(negedge CLK);
        @(posedge CLK);
        #1 b.halt_req = 1'b1;
        for (int i = 0; i < 50 && !b.halted; i++) @(negedge CLK);
        b.halt_req = 1'b0;
        m_pc = 4'd1;
        m_retired += 17;
        chk("wrap_halted", 32'(b.halted), 32'd1);
        chk("wrap_retired", 32'(b.retired), 32'(m_retired));
        chk("wrap_pc", 32'(b.rom_addr), 32'(m_pc));
        chk("wrap_drained", 32'(q.size()), 32'd0);

        rom[5] = {4'h1, 28'($urandom)};
        q.push_back(mk(4'd5, rom[5]));
        go(1, 4'd5);
        for (int i = 0; i < 50 && !b.rf_ld; i++) @(negedge CLK);
        chk("mid_rf_ld", 32'(b.rf_ld), 32'd1);
        b.halt_req = 1'b1;
        for (int i = 0; i < 50 && !b.halted; i++) @(negedge CLK);
        b.halt_req = 1'b0;
        m_retired++;
        chk("hreq_halted", 32'(b.halted), 32'd1);
        chk("hreq_pc", 32'(b.rom_addr), 32'd6);
        chk("hreq_retired", 32'(b.retired), 32'(m_retired));
        chk("hreq_drained", 32'(q.size()), 32'd0);

        // Asynchronous reset while in LOAD; checked between clock edges
        b.step_mode = 1'b1;
        rom[7] = {4'h1, 28'($urandom)};
        q.push_back(mk(4'd7, rom[7]));
        go(1, 4'd7);
        for (int i = 0; i < 50 && !b.rf_ld; i++) @(negedge CLK);
        #1 RESET = 1'b1;
        #1;
        chk("arst_rf_ld", 32'(b.rf_ld), 32'd0);
        chk("arst_busy", 32'(b.busy), 32'd0);
        chk("arst_retired", 32'(b.retired), 32'd0);
        chk("arst_pc", 32'(b.rom_addr), 32'd0);
        chk("arst_fault", 32'(b.fault), 32'd0);
        q.delete();
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        m_pc = '0;
        m_retired = 0;
        m_fault = 1'b0;
        rom[0] = {4'h1, 28'($urandom)};
        run_one(0, 4'd0);

        // Non-wrapping instance with a 4-bit counter: halts on the last word, count saturates
        for (int i = 0; i < 16; i++) rom[i] = {4'h0, 28'($urandom)};
        st2 = 0;
        b2.start = 1'b1;
        @(negedge CLK);
        b2.start = 1'b0;
        for (int i = 0; i < 300 && !b2.halted; i++) @(negedge CLK);
        chk("nw_halted", 32'(b2.halted), 32'd1);
        chk("nw_pc", 32'(b2.rom_addr), 32'd15);
        chk("nw_retired_sat", 32'(b2.retired), 32'd15);
        chk("nw_stores", 32'(st2), 32'd16);
        chk("nw_fault", 32'(b2.fault), 32'd0);
        chk("final_drained", 32'(q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
